// File: rtl/tl_axi_bridge.sv
// TileLink-UL manager to AXI4 manager bridge with a single outstanding transaction.
// Get maps to AR/R, PutFull/PutPartial to AW/W/B; other opcodes are drained and denied.
module tl_axi_bridge #(
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned SourceWidth = 1,
  parameter int unsigned SinkWidth   = 1,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned SizeWidth   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  // TL A
  input  logic                   a_valid,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [SizeWidth-1:0]   a_size,
  input  logic [SourceWidth-1:0] a_source,
  input  logic [AddrWidth-1:0]   a_address,
  input  logic [DataWidth/8-1:0] a_mask,
  input  logic                   a_corrupt,
  input  logic [DataWidth-1:0]   a_data,
  output logic                   a_ready,
  // TL D
  output logic                   d_valid,
  output logic [2:0]             d_opcode,
  output logic [1:0]             d_param,
  output logic [SizeWidth-1:0]   d_size,
  output logic [SourceWidth-1:0] d_source,
  output logic [SinkWidth-1:0]   d_sink,
  output logic                   d_denied,
  output logic                   d_corrupt,
  output logic [DataWidth-1:0]   d_data,
  input  logic                   d_ready,
  // AXI AW
  output logic                   aw_valid,
  output logic [IdWidth-1:0]     aw_id,
  output logic [AddrWidth-1:0]   aw_addr,
  output logic [7:0]             aw_len,
  output logic [2:0]             aw_size,
  output logic [1:0]             aw_burst,
  input  logic                   aw_ready,
  // AXI W
  output logic                   w_valid,
  output logic [DataWidth-1:0]   w_data,
  output logic [DataWidth/8-1:0] w_strb,
  output logic                   w_last,
  input  logic                   w_ready,
  // AXI B
  input  logic                   b_valid,
  input  logic [IdWidth-1:0]     b_id,
  input  logic [1:0]             b_resp,
  output logic                   b_ready,
  // AXI AR
  output logic                   ar_valid,
  output logic [IdWidth-1:0]     ar_id,
  output logic [AddrWidth-1:0]   ar_addr,
  output logic [7:0]             ar_len,
  output logic [2:0]             ar_size,
  output logic [1:0]             ar_burst,
  input  logic                   ar_ready,
  // AXI R
  input  logic                   r_valid,
  input  logic [IdWidth-1:0]     r_id,
  input  logic [DataWidth-1:0]   r_data,
  input  logic [1:0]             r_resp,
  input  logic                   r_last,
  output logic                   r_ready
);

  localparam int unsigned MaskWidth = DataWidth / 8;
  localparam int unsigned LogBb     = $clog2(MaskWidth);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WDATA    = 3'd1;
  localparam logic [2:0] ST_WRESP    = 3'd2;
  localparam logic [2:0] ST_RDATA    = 3'd3;
  localparam logic [2:0] ST_ERRDRAIN = 3'd4;
  localparam logic [2:0] ST_ERRRESP  = 3'd5;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_LOGICAL     = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;

  logic [2:0]             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             len_q, len_d;
  logic [SizeWidth-1:0]   size_q, size_d;
  logic [SourceWidth-1:0] source_q, source_d;

  logic [7:0] hdr_len_c;
  logic [2:0] hdr_axsize_c;
  logic       is_get, is_put, is_data;

  assign is_get  = (a_opcode == OP_GET);
  assign is_put  = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
  assign is_data = (a_opcode <= OP_LOGICAL);

  // Burst shape: transfers wider than the bus split into full-width beats
  always_comb begin
    hdr_len_c    = 8'd0;
    hdr_axsize_c = 3'(a_size);
    if (a_size > SizeWidth'(LogBb)) begin
      hdr_len_c    = 8'((32'd1 << (32'(a_size) - 32'(LogBb))) - 32'd1);
      hdr_axsize_c = 3'(LogBb);
    end
  end

  assign aw_id     = '0;
  assign aw_addr   = a_address;
  assign aw_len    = hdr_len_c;
  assign aw_size   = hdr_axsize_c;
  assign aw_burst  = 2'b01;
  assign ar_id     = '0;
  assign ar_addr   = a_address;
  assign ar_len    = hdr_len_c;
  assign ar_size   = hdr_axsize_c;
  assign ar_burst  = 2'b01;
  assign w_data    = a_data;
  assign w_strb    = a_mask;
  assign w_last    = (cnt_q == len_q);
  assign d_param   = 2'b00;
  assign d_size    = size_q;
  assign d_source  = source_q;
  assign d_sink    = '0;
  assign d_corrupt = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      len_q    <= 8'd0;
      size_q   <= '0;
      source_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      size_q   <= size_d;
      source_q <= source_d;
    end
  end

  // Next state and zero-latency handshake routing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    size_d   = size_q;
    source_d = source_q;
    a_ready  = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    d_valid  = 1'b0;
    d_opcode = D_ACK;
    d_denied = 1'b0;
    d_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (a_valid) begin
          if (is_get) begin
            ar_valid = 1'b1;
            a_ready  = ar_ready;
            if (ar_ready) begin
              size_d   = a_size;
              source_d = a_source;
              len_d    = hdr_len_c;
              cnt_d    = 8'd0;
              state_d  = ST_RDATA;
            end
          end else if (is_put) begin
            // The first A beat stays on the bus until it moves to W
            aw_valid = 1'b1;
            if (aw_ready) begin
              size_d   = a_size;
              source_d = a_source;
              len_d    = hdr_len_c;
              cnt_d    = 8'd0;
              state_d  = ST_WDATA;
            end
          end else begin
            size_d   = a_size;
            source_d = a_source;
            len_d    = is_data ? hdr_len_c : 8'd0;
            cnt_d    = 8'd0;
            state_d  = ST_ERRDRAIN;
          end
        end
      end
      ST_WDATA: begin
        w_valid = a_valid;
        a_ready = w_ready;
        if (a_valid && w_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        d_valid  = b_valid;
        b_ready  = d_ready;
        d_denied = b_resp[1];
        if (b_valid && d_ready) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        d_valid  = r_valid;
        r_ready  = d_ready;
        d_opcode = D_ACK_DATA;
        d_data   = r_data;
        d_denied = r_resp[1];
        if (r_valid && d_ready && r_last) state_d = ST_IDLE;
      end
      ST_ERRDRAIN: begin
        a_ready = 1'b1;
        if (a_valid) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = ST_ERRRESP;
        end
      end
      ST_ERRRESP: begin
        d_valid  = 1'b1;
        d_denied = 1'b1;
        if (d_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      a_ready  = 1'b0;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      d_valid  = 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{a_param, a_corrupt, b_id, r_id, b_resp[0], r_resp[0]};

endmodule
